hazard_pipe_tracker: RTL and testbench

// Carries each instruction's opcode and register fields through the ID->EX->MEM->WB pipeline registers.

---
 rtl/pipeline_pkg.sv | 40 ++++
 rtl/hazard_stall_detect.sv | 51 +++++
 rtl/hazard_pipe_tracker.sv | 125 ++++++++++++
 tb/tb_hazard_pipe_tracker.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - opcodes and register-usage helpers shared by the hazard and forwarding logic
package pipeline_pkg;

    localparam int OPW_P  = 6;
    localparam int REGW_P = 5;

    localparam logic [OPW_P-1:0] RTYPE  = 6'h00;
    localparam logic [OPW_P-1:0] J      = 6'h02;
    localparam logic [OPW_P-1:0] BEQ    = 6'h04;
    localparam logic [OPW_P-1:0] BNE    = 6'h05;
    localparam logic [OPW_P-1:0] ADDI   = 6'h08;
    localparam logic [OPW_P-1:0] SLTI   = 6'h0A;
    localparam logic [OPW_P-1:0] LW     = 6'h23;
    localparam logic [OPW_P-1:0] SW     = 6'h2B;
    // Unsupported opcode: no forwarding detector ever matches it.
    localparam logic [OPW_P-1:0] BUBBLE = 6'h3F;

    // Destination register written by op; 0 means "writes nothing".
    function automatic logic [REGW_P-1:0] dest_reg(input logic [OPW_P-1:0] op,
                                                   input logic [REGW_P-1:0] rt,
                                                   input logic [REGW_P-1:0] rd);
        logic [REGW_P-1:0] d;
        d = '0;
        if (op == RTYPE)
            d = rd;
        else if (op == LW || op == ADDI || op == SLTI)
            d = rt;
        return d;
    endfunction

    function automatic logic reads_rs(input logic [OPW_P-1:0] op);
        return (op == RTYPE) || (op == LW) || (op == SW) || (op == ADDI) ||
               (op == SLTI)  || (op == BEQ) || (op == BNE);
    endfunction

    function automatic logic reads_rt(input logic [OPW_P-1:0] op);
        return (op == RTYPE) || (op == SW) || (op == BEQ) || (op == BNE);
    endfunction

endpackage

// File: rtl/hazard_stall_detect.sv
// rtl/hazard_stall_detect.sv - combinational load-use / branch-on-ALU / branch-on-load stall detection
//
// Ports:
//   IDop, IDrs, IDrt, IDvalid : instruction currently in decode
//   EXop, EXrt, EXrd          : instruction in EX (registered by the top)
//   MEMop, MEMrt              : instruction in MEM (registered by the top)
//   stall                     : hold PC and IF/ID, bubble EX
module hazard_stall_detect
    import pipeline_pkg::*;
(
    input  logic [OPW_P-1:0]  IDop,
    input  logic [REGW_P-1:0] IDrs,
    input  logic [REGW_P-1:0] IDrt,
    input  logic              IDvalid,
    input  logic [OPW_P-1:0]  EXop,
    input  logic [REGW_P-1:0] EXrt,
    input  logic [REGW_P-1:0] EXrd,
    input  logic [OPW_P-1:0]  MEMop,
    input  logic [REGW_P-1:0] MEMrt,
    output logic              stall
);

    // $0 is hard-wired, so a zero register never produces a dependency.
    function automatic logic id_reads(input logic [REGW_P-1:0] r,
                                      input logic [OPW_P-1:0]  op,
                                      input logic [REGW_P-1:0] rs,
                                      input logic [REGW_P-1:0] rt);
        return (r != '0) &&
               ((reads_rs(op) && rs == r) || (reads_rt(op) && rt == r));
    endfunction

    logic w_id_branch;
    logic w_load_use;
    logic w_branch_alu;
    logic w_branch_load;

    assign w_id_branch   = (IDop == BEQ) || (IDop == BNE);

    assign w_load_use    = (EXop == LW) && id_reads(EXrt, IDop, IDrs, IDrt);

    // Branches compare in ID, so any EX result they need is not ready yet.
    assign w_branch_alu  = w_id_branch &&
                           id_reads(dest_reg(EXop, EXrt, EXrd), IDop, IDrs, IDrt);

    // Load data only exists at the end of MEM; there is no MEM->ID path for it.
    assign w_branch_load = w_id_branch && (MEMop == LW) &&
                           id_reads(MEMrt, IDop, IDrs, IDrt);

    assign stall = IDvalid && (w_load_use || w_branch_alu || w_branch_load);

endmodule

// File: rtl/hazard_pipe_tracker.sv
// rtl/hazard_pipe_tracker.sv - ID->EX->MEM->WB op/register tracking with hazard stall and stall counter
//
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   IDop, IDrs, IDrt, IDrd       : decoded instruction in ID
//   IDvalid                      : ID holds a real instruction
//   flush                        : squash ID slot, EX receives a bubble
//   EX/MEM/WB op, rs, rt, rd     : registered stage fields for the forwarding detectors
//   stall                        : combinational stall request
//   stall_cycles                 : saturating count of stalled cycles
module hazard_pipe_tracker
    import pipeline_pkg::*;
#(
    parameter int OPW  = OPW_P,
    parameter int REGW = REGW_P,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [OPW-1:0]  IDop,
    input  logic [REGW-1:0] IDrs,
    input  logic [REGW-1:0] IDrt,
    input  logic [REGW-1:0] IDrd,
    input  logic            IDvalid,
    input  logic            flush,
    output logic [OPW-1:0]  EXop,
    output logic [OPW-1:0]  MEMop,
    output logic [OPW-1:0]  WBop,
    output logic [REGW-1:0] EXrs,
    output logic [REGW-1:0] EXrt,
    output logic [REGW-1:0] EXrd,
    output logic [REGW-1:0] MEMrs,
    output logic [REGW-1:0] MEMrt,
    output logic [REGW-1:0] MEMrd,
    output logic [REGW-1:0] WBrs,
    output logic [REGW-1:0] WBrt,
    output logic [REGW-1:0] WBrd,
    output logic            stall,
    output logic [CNTW-1:0] stall_cycles
);

    logic [OPW-1:0]  r_ex_op,  r_mem_op, r_wb_op;
    logic [REGW-1:0] r_ex_rs,  r_ex_rt,  r_ex_rd;
    logic [REGW-1:0] r_mem_rs, r_mem_rt, r_mem_rd;
    logic [REGW-1:0] r_wb_rs,  r_wb_rt,  r_wb_rd;
    logic [CNTW-1:0] r_stall_cycles;
    logic            w_stall;
    logic            w_ex_bubble;

    hazard_stall_detect u_detect (
        .IDop    (IDop),
        .IDrs    (IDrs),
        .IDrt    (IDrt),
        .IDvalid (IDvalid),
        .EXop    (r_ex_op),
        .EXrt    (r_ex_rt),
        .EXrd    (r_ex_rd),
        .MEMop   (r_mem_op),
        .MEMrt   (r_mem_rt),
        .stall   (w_stall)
    );

    assign w_ex_bubble = w_stall || flush || !IDvalid;

    // MEM and WB always advance; only the ID->EX hop is gated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_op  <= OPW'(BUBBLE);
            r_mem_op <= OPW'(BUBBLE);
            r_wb_op  <= OPW'(BUBBLE);
            r_ex_rs  <= '0;
            r_ex_rt  <= '0;
            r_ex_rd  <= '0;
            r_mem_rs <= '0;
            r_mem_rt <= '0;
            r_mem_rd <= '0;
            r_wb_rs  <= '0;
            r_wb_rt  <= '0;
            r_wb_rd  <= '0;
        end else begin
            r_wb_op  <= r_mem_op;
            r_wb_rs  <= r_mem_rs;
            r_wb_rt  <= r_mem_rt;
            r_wb_rd  <= r_mem_rd;
            r_mem_op <= r_ex_op;
            r_mem_rs <= r_ex_rs;
            r_mem_rt <= r_ex_rt;
            r_mem_rd <= r_ex_rd;
            if (w_ex_bubble) begin
                r_ex_op <= OPW'(BUBBLE);
                r_ex_rs <= '0;
                r_ex_rt <= '0;
                r_ex_rd <= '0;
            end else begin
                r_ex_op <= IDop;
                r_ex_rs <= IDrs;
                r_ex_rt <= IDrt;
                r_ex_rd <= IDrd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stall_cycles <= '0;
        else if (w_stall && (r_stall_cycles != {CNTW{1'b1}}))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign EXop         = r_ex_op;
    assign MEMop        = r_mem_op;
    assign WBop         = r_wb_op;
    assign EXrs         = r_ex_rs;
    assign EXrt         = r_ex_rt;
    assign EXrd         = r_ex_rd;
    assign MEMrs        = r_mem_rs;
    assign MEMrt        = r_mem_rt;
    assign MEMrd        = r_mem_rd;
    assign WBrs         = r_wb_rs;
    assign WBrt         = r_wb_rt;
    assign WBrd         = r_wb_rd;
    assign stall        = w_stall;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// tb/tb_hazard_pipe_tracker.sv - scoreboard bench for hazard_pipe_tracker
module tb_hazard_pipe_tracker;
    import pipeline_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] IDop = BUBBLE;
    logic [4:0] IDrs = '0, IDrt = '0, IDrd = '0;
    logic       IDvalid = 1'b0, flush = 1'b0;
    logic [5:0] EXop, MEMop, WBop;
    logic [4:0] EXrs, EXrt, EXrd, MEMrs, MEMrt, MEMrd, WBrs, WBrt, WBrd;
    logic       stall;
    logic [1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_pipe_tracker #(.CNTW(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .IDop(IDop), .IDrs(IDrs), .IDrt(IDrt), .IDrd(IDrd),
        .IDvalid(IDvalid), .flush(flush),
        .EXop(EXop), .MEMop(MEMop), .WBop(WBop),
        .EXrs(EXrs), .EXrt(EXrt), .EXrd(EXrd),
        .MEMrs(MEMrs), .MEMrt(MEMrt), .MEMrd(MEMrd),
        .WBrs(WBrs), .WBrt(WBrt), .WBrd(WBrd),
        .stall(stall), .stall_cycles(stall_cycles)
    );

    // -1 in any field means "not checked this cycle".
    typedef struct {
        string tag;
        int stall, exop, exrs, exrt, exrd, memop, memrt, wbop, cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        if (exp < 0) return;
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Monitor: every negedge, compare DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, ".stall"},        int'(stall),        e.stall);
                chk({e.tag, ".EXop"},         int'(EXop),         e.exop);
                chk({e.tag, ".EXrs"},         int'(EXrs),         e.exrs);
                chk({e.tag, ".EXrt"},         int'(EXrt),         e.exrt);
                chk({e.tag, ".EXrd"},         int'(EXrd),         e.exrd);
                chk({e.tag, ".MEMop"},        int'(MEMop),        e.memop);
                chk({e.tag, ".MEMrt"},        int'(MEMrt),        e.memrt);
                chk({e.tag, ".WBop"},         int'(WBop),         e.wbop);
                chk({e.tag, ".stall_cycles"}, int'(stall_cycles), e.cnt);
            end
        end
    end

    task automatic step(input string tag, input int op, input int rs, input int rt, input int rd,
                        input logic v, input logic f,
                        input int es, input int eexop, input int eexrs, input int eexrt,
                        input int eexrd, input int ememop, input int ememrt, input int ewbop,
                        input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        IDop = 6'(op); IDrs = 5'(rs); IDrt = 5'(rt); IDrd = 5'(rd);
        IDvalid = v; flush = f;
        e.tag = tag; e.stall = es; e.exop = eexop; e.exrs = eexrs; e.exrt = eexrt;
        e.exrd = eexrd; e.memop = ememop; e.memrt = ememrt; e.wbop = ewbop; e.cnt = ecnt;
        sb.push_back(e);
    endtask

    localparam int B = 63;

    initial begin
        int wait_cycles;
        // Reset state
        step("rst",          B,    0,0,0, 0,0,  0, B,    0,0,0,  B,    0, B,    0);
        @(negedge clk); #2 reset_n = 1'b1;
        // Load-use
        step("lu_issue",     LW,   1,5,0, 1,0,  0, B,   -1,-1,-1, B,   -1, B,    0);
        step("lu_stall",     RTYPE,5,2,3, 1,0,  1, LW,   1,5,-1,  B,   -1,-1,    0);
        step("lu_hold",      RTYPE,5,2,3, 1,0,  0, B,    0,0,0,   LW,   5,-1,    1);
        step("lu_fwd",       B,    0,0,0, 0,0,  0, RTYPE,5,2,3,   B,   -1, LW,   1);
        // Branch after ALU
        step("alu_issue",    ADDI, 1,7,0, 1,0,  0, B,   -1,-1,-1, RTYPE,-1, B,   1);
        step("br_alu_stall", BEQ,  7,0,0, 1,0,  1, ADDI, 1,7,-1,  B,   -1,-1,    1);
        step("br_alu_go",    BEQ,  7,0,0, 1,0,  0, B,   -1,-1,-1, ADDI, 7, B,    2);
        step("br_alu_ex",    B,    0,0,0, 0,0,  0, BEQ,  7,0,0,   B,   -1, ADDI, 2);
        // Branch after load: two stall cycles, counter saturates at 3
        step("ld_issue",     LW,   0,9,0, 1,0,  0, B,   -1,-1,-1, BEQ, -1, B,    2);
        step("br_ld_a",      BNE,  0,9,0, 1,0,  1, LW,   0,9,-1,  B,   -1, BEQ,  2);
        step("br_ld_c",      BNE,  0,9,0, 1,0,  1, B,   -1,-1,-1, LW,   9, B,    3);
        step("br_ld_sat",    BNE,  0,9,0, 1,0,  0, B,   -1,-1,-1, B,   -1, LW,   3);
        step("br_ld_ex",     B,    0,0,0, 0,0,  0, BNE,  0,9,-1,  B,   -1, B,    3);
        // $0 and non-hazards
        step("z_issue",      LW,   0,0,0, 1,0,  0, B,   -1,-1,-1, BNE, -1, B,    3);
        step("z_use",        RTYPE,0,0,4, 1,0,  0, LW,   0,0,-1,  B,   -1, BNE,  3);
        step("sw_issue",     SW,   1,5,0, 1,0,  0, RTYPE,-1,-1,4, LW,   0, B,    3);
        step("sw_use",       BEQ,  5,5,0, 1,0,  0, SW,   1,5,-1,  RTYPE,-1, LW,  3);
        step("flush",        RTYPE,1,2,3, 1,1,  0, BEQ,  5,5,-1,  SW,   5, RTYPE,3);
        step("flush_ex",     B,    0,0,0, 0,0,  0, B,    0,0,0,   BEQ, -1, SW,   3);
        // Stall and flush together
        step("sf_issue",     LW,   0,6,0, 1,0,  0, B,   -1,-1,-1, B,   -1, BEQ,  3);
        step("sf_stall",     RTYPE,6,0,1, 1,1,  1, LW,   0,6,-1,  B,   -1, B,    3);
        step("sf_adv",       B,    0,0,0, 0,0,  0, B,    0,0,0,   LW,   6, B,    3);
        // Reset mid-stall
        step("rs_issue",     LW,   0,8,0, 1,0,  0, B,   -1,-1,-1, B,   -1, LW,   3);
        step("rs_stall",     RTYPE,8,0,1, 1,0,  1, LW,   0,8,-1,  B,   -1, B,    3);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst.stall",        int'(stall),        0);
        chk("async_rst.EXop",         int'(EXop),         B);
        chk("async_rst.EXrt",         int'(EXrt),         0);
        chk("async_rst.MEMop",        int'(MEMop),        B);
        chk("async_rst.stall_cycles", int'(stall_cycles), 0);
        step("rs_hold",      B,    0,0,0, 0,0,  0, B,    0,0,0,   B,    0, B,    0);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
